// File: rtl/dino_pkg.sv
// Shared dinosaur definitions: frame encoding, default geometry and the sprite bitmaps.
// The bitmaps are built by constant functions, so the ROM is fixed at elaboration.
package dino_pkg;

    localparam int DEF_SPR_W        = 88;
    localparam int DEF_SPR_H        = 88;
    localparam int DEF_DUCK_H       = 52;
    localparam int DEF_X0           = 80;
    localparam int DEF_GROUND       = 402;
    localparam int DEF_JUMP_FRAMES  = 64;
    localparam int DEF_HEIGHT_SHIFT = 3;
    localparam int DEF_RUN_PERIOD   = 6;
    localparam int DEF_ROW_W        = 9;
    localparam int DEF_COL_W        = 10;

    localparam int SPR_RW = $clog2(DEF_SPR_H);
    localparam int SPR_CW = $clog2(DEF_SPR_W);

    typedef enum logic [1:0] {
        STAND = 2'd0,
        RUN_A = 2'd1,
        RUN_B = 2'd2,
        DUCK  = 2'd3
    } frame_sel_t;

    function automatic logic [DEF_SPR_W-1:0] span(input int lo, input int hi);
        logic [DEF_SPR_W-1:0] m;
        m = '0;
        for (int i = 0; i < DEF_SPR_W; i++) begin
            if (i >= lo && i <= hi) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Word bit b of a row is displayed at sprite column DEF_SPR_W-1-b (mirrored).
    function automatic logic [DEF_SPR_W-1:0] sprite_row(input logic [1:0] frame, input int r);
        logic [DEF_SPR_W-1:0] w;
        w = '0;
        if (frame == DUCK) begin
            if (r >= 36 && r < 56) w = span(40, 87);
            if (r >= 56 && r < 78) w = span(0, 79);
            if (r >= 78)           w = span(0, 11) | span(50, 61);
        end else begin
            if (r < 22)            w = span(44, 87);
            if (r >= 6 && r < 10)  w = w & ~span(52, 55);
            if (r >= 22 && r < 56) w = span(8, 59);
            if (r >= 30 && r < 36) w = w | span(60, 71);
            if (r >= 56 && r < 70) w = span(0, 47);
            if (r >= 70) begin
                if (frame != RUN_B) w = w | span(0, 11);
                if (frame != RUN_A) w = w | span(36, 47);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dino_sprite_rom.sv
// Synchronous-read sprite ROM: one registered pixel per clock, column mirrored
// within the stored row word.
module dino_sprite_rom
    import dino_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        frame,
    input  logic [SPR_RW-1:0] row,
    input  logic [SPR_CW-1:0] col,
    output logic              pix
);

    localparam logic [SPR_CW-1:0] LAST_COL = SPR_CW'(DEF_SPR_W - 1);

    logic [DEF_SPR_W-1:0] word;

    always_comb begin
        word = sprite_row(frame, int'(row));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix <= 1'b0;
        end else begin
            pix <= word[LAST_COL - col];
        end
    end

endmodule

// File: rtl/dino_sprite_engine.sv
// Dinosaur per-frame state (jump arc, duck, run legs) and a 2-stage sprite pixel
// pipeline in the pixel clock domain; exports the bounding box for collision.
module dino_sprite_engine
    import dino_pkg::*;
#(
    parameter int SPR_W        = DEF_SPR_W,
    parameter int SPR_H        = DEF_SPR_H,
    parameter int DUCK_H       = DEF_DUCK_H,
    parameter int X0           = DEF_X0,
    parameter int GROUND       = DEF_GROUND,
    parameter int JUMP_FRAMES  = DEF_JUMP_FRAMES,
    parameter int HEIGHT_SHIFT = DEF_HEIGHT_SHIFT,
    parameter int RUN_PERIOD   = DEF_RUN_PERIOD,
    parameter int ROW_W        = DEF_ROW_W,
    parameter int COL_W        = DEF_COL_W
)(
    input  logic             clk,
    input  logic             RESET,
    input  logic             frame_tick,
    input  logic             game_status,
    input  logic             start,
    input  logic             button_jump,
    input  logic             button_duck,
    input  logic [ROW_W-1:0] row_addr,
    input  logic [COL_W-1:0] col_addr,
    output logic             px,
    output logic             jumping,
    output logic [ROW_W-1:0] height,
    output logic [ROW_W-1:0] box_top,
    output logic [ROW_W-1:0] box_bottom
);

    localparam int JT_W = $clog2(JUMP_FRAMES);
    localparam int PW   = 2 * $clog2(JUMP_FRAMES + 1);
    localparam int RC_W = (RUN_PERIOD > 1) ? $clog2(RUN_PERIOD) : 1;

    localparam logic [JT_W-1:0]  LAST_T    = JT_W'(JUMP_FRAMES - 1);
    localparam logic [RC_W-1:0]  LAST_RUN  = RC_W'(RUN_PERIOD - 1);
    localparam logic [PW-1:0]    MAX_H_P   = PW'(GROUND - SPR_H);
    localparam logic [PW-1:0]    JF_P      = PW'(JUMP_FRAMES);
    localparam logic [ROW_W-1:0] MAX_H     = ROW_W'(GROUND - SPR_H);
    localparam logic [ROW_W-1:0] GROUND_R  = ROW_W'(GROUND);
    localparam logic [ROW_W-1:0] SPR_H_R   = ROW_W'(SPR_H);
    localparam logic [ROW_W-1:0] DUCK_H_R  = ROW_W'(DUCK_H);
    localparam logic [ROW_W:0]   SPR_H_X   = (ROW_W+1)'(SPR_H);
    localparam logic [COL_W-1:0] X0_C      = COL_W'(X0);
    localparam logic [COL_W-1:0] X_END_C   = COL_W'(X0 + SPR_W);

    logic [JT_W-1:0]  jump_t;
    logic [JT_W-1:0]  jt_next;
    logic             jumping_next;
    logic [RC_W-1:0]  run_cnt;
    logic [RC_W-1:0]  run_cnt_next;
    logic             leg;
    logic             leg_next;
    frame_sel_t       frame_sel;
    frame_sel_t       frame_next;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    scaled;
    logic [ROW_W-1:0] height_next;

    always_comb begin
        jumping_next = jumping;
        jt_next      = jump_t;
        if (!jumping) begin
            if (button_jump) begin
                jumping_next = 1'b1;
                jt_next      = JT_W'(1);
            end
        end else if (jump_t == LAST_T) begin
            jumping_next = 1'b0;
            jt_next      = '0;
        end else begin
            jt_next = jump_t + 1'b1;
        end

        // Full-width product so the parabola is exact before the shift.
        prod        = PW'(jt_next) * (JF_P - PW'(jt_next));
        scaled      = prod >> HEIGHT_SHIFT;
        height_next = (scaled > MAX_H_P) ? MAX_H : ROW_W'(scaled);

        run_cnt_next = run_cnt;
        leg_next     = leg;
        if (!jumping_next && !button_duck) begin
            if (run_cnt == LAST_RUN) begin
                run_cnt_next = '0;
                leg_next     = ~leg;
            end else begin
                run_cnt_next = run_cnt + 1'b1;
            end
        end

        if (jumping_next) begin
            frame_next = STAND;
        end else if (button_duck) begin
            frame_next = DUCK;
        end else begin
            frame_next = leg_next ? RUN_B : RUN_A;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            jumping   <= 1'b0;
            jump_t    <= '0;
            height    <= '0;
            run_cnt   <= '0;
            leg       <= 1'b0;
            frame_sel <= STAND;
        end else if (frame_tick) begin
            if (game_status) begin
                jumping   <= jumping_next;
                jump_t    <= jt_next;
                height    <= height_next;
                run_cnt   <= run_cnt_next;
                leg       <= leg_next;
                frame_sel <= frame_next;
            end else if (start) begin
                jumping   <= 1'b0;
                jump_t    <= '0;
                height    <= '0;
                frame_sel <= STAND;
            end
        end
    end

    assign box_bottom = GROUND_R - height;
    assign box_top    = box_bottom - ((frame_sel == DUCK) ? DUCK_H_R : SPR_H_R);

    // Row test is done as row+SPR_H >= bottom in one extra bit so it never wraps.
    logic [ROW_W:0] row_ext;
    logic [ROW_W:0] bot_ext;
    logic           row_hit;
    logic           col_hit;

    always_comb begin
        row_ext = {1'b0, row_addr};
        bot_ext = {1'b0, box_bottom};
        row_hit = (row_ext + SPR_H_X >= bot_ext) && (row_ext < bot_ext);
        col_hit = (col_addr >= X0_C) && (col_addr < X_END_C);
    end

    logic              s1_hit;
    logic [SPR_RW-1:0] s1_r;
    logic [SPR_CW-1:0] s1_c;
    logic              s2_hit;
    logic              rom_pix;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            s1_hit <= 1'b0;
            s1_r   <= '0;
            s1_c   <= '0;
            s2_hit <= 1'b0;
        end else begin
            s1_hit <= row_hit && col_hit;
            s2_hit <= s1_hit;
            if (row_hit && col_hit) begin
                s1_r <= SPR_RW'(row_ext + SPR_H_X - bot_ext);
                s1_c <= SPR_CW'(col_addr - X0_C);
            end else begin
                s1_r <= '0;
                s1_c <= '0;
            end
        end
    end

    dino_sprite_rom u_rom (
        .clk   (clk),
        .rst   (RESET),
        .frame (frame_sel),
        .row   (s1_r),
        .col   (s1_c),
        .pix   (rom_pix)
    );

    assign px = s2_hit & rom_pix;

endmodule
